// File: rtl/uart_program_loader.sv
// ---------------------------------------------------------------------------
// uart_program_loader
//
// Boot-time loader. Receives a program image over an 8N1 UART line and writes
// it word by word into the instruction/data RAM. The CPU is held in reset
// until a complete image with a matching checksum has been written.
//
// Frame: SYNC_BYTE, LEN_LO, LEN_HI, 4*N data bytes (little-endian words), CSUM
//        where CSUM is the XOR of all data bytes (0x00 for N = 0).
//
// Ports:
//   clk_i        system clock
//   reset_ni     asynchronous active-low reset
//   rx_i         UART serial input (idle high, asynchronous to clk_i)
//   ram_we_o     RAM write strobe, one cycle per word
//   ram_addr_o   RAM word address (holds last value when ram_we_o = 0)
//   ram_wdata_o  RAM write data   (holds last value when ram_we_o = 0)
//   cpu_hold_o   1 = keep the CPU in reset
//   done_o       image loaded and checksum valid (sticky until reset)
//   error_o      framing, length or checksum error (sticky until next sync)
// ---------------------------------------------------------------------------
module uart_program_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          ADDR_WIDTH   = 10,
    parameter int          DEPTH        = 1024,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  rx_i,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic                  cpu_hold_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // Start-bit recheck lands roughly in the middle of the start bit.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      DEPTH_W  = 17'(DEPTH);

    // ------------------------------------------------------------------
    // RX synchronizer and edge detector
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ------------------------------------------------------------------
    // RX byte receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_WAIT_START,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid;
    logic             frame_err;
    logic [7:0]       rx_byte;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx_state_q <= RX_WAIT_START;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;

        case (rx_state_q)
            RX_WAIT_START: begin
                // A real falling edge is required, so a line left low after
                // a bad stop bit does not retrigger reception.
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_state_d = RX_WAIT_START;   // glitch, not a start bit
                    end else begin
                        rx_state_d = RX_DATA;
                        bit_idx_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};   // LSB first
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    rx_state_d = RX_WAIT_START;
                    if (rx_sync_q) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_WAIT_START;
        endcase
    end

    assign rx_byte = shift_q;

    // ------------------------------------------------------------------
    // Frame parser / RAM writer
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           word_q, word_d;
    logic [7:0]            xor_q, xor_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]           ram_wdata_q, ram_wdata_d;
    logic [15:0]           n_len;
    logic [31:0]           word_next;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            len_lo_q    <= '0;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            xor_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            xor_q       <= xor_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Little-endian assembly: each new byte enters at the top and the word
    // shifts down, so after four bytes the first one sits in bits [7:0].
    assign n_len     = {rx_byte, len_lo_q};
    assign word_next = {rx_byte, word_q[31:8]};

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        xor_d       = xor_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        if (frame_err && (state_q != ST_DONE)) begin
            state_d = ST_ERROR;
        end else if (byte_valid) begin
            case (state_q)
                ST_IDLE, ST_ERROR: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d    = ST_LEN0;
                        xor_d      = '0;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                    end
                end
                ST_LEN0: begin
                    len_lo_d = rx_byte;
                    state_d  = ST_LEN1;
                end
                ST_LEN1: begin
                    len_d      = n_len;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    if ({1'b0, n_len} > DEPTH_W) begin
                        state_d = ST_ERROR;
                    end else if (n_len == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    xor_d      = xor_q ^ rx_byte;
                    word_d     = word_next;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        ram_we_d    = 1'b1;
                        ram_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                        ram_wdata_d = word_next;
                        word_idx_d  = word_idx_q + 16'd1;
                        if (word_idx_q == (len_q - 16'd1)) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    state_d = (rx_byte == xor_q) ? ST_DONE : ST_ERROR;
                end
                default: ;   // DONE is terminal
            endcase
        end
    end

    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign done_o      = (state_q == ST_DONE);
    assign error_o     = (state_q == ST_ERROR);
    assign cpu_hold_o  = (state_q != ST_DONE);

endmodule

// File: tb/tb_uart_program_loader.sv
// ---------------------------------------------------------------------------
// Directed testbench for uart_program_loader with CLKS_PER_BIT = 4.
// Bytes are driven on rx at negative edges; outputs are sampled at negative
// edges. A monitor records every ram_we cycle into queues.
// ---------------------------------------------------------------------------
module tb_uart_program_loader;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;

    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  frame[$];

    uart_program_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_WIDTH   (10),
        .DEPTH        (1024),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .rx_i        (rx),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .cpu_hold_o  (cpu_hold),
        .done_o      (done),
        .error_o     (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_we) begin
            wr_addr.push_back(ram_addr);
            wr_data.push_back(ram_wdata);
            $display("[TB] write addr=%0d data=%08h", ram_addr, ram_wdata);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i], 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rx = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic test_reset();
        rx = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL reset_we got=%b exp=0", ram_we); end
        tests++; if (ram_addr !== 10'd0) begin fails++; $display("FAIL reset_addr got=%0h exp=0", ram_addr); end
        tests++; if (ram_wdata !== 32'd0) begin fails++; $display("FAIL reset_wdata got=%08h exp=0", ram_wdata); end
        tests++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL reset_hold got=%b exp=1", cpu_hold); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error got=%b exp=0", error); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] test_reset complete");
    endtask

    // Checksum of 78 56 34 12 EF BE AD DE is their XOR = 0x2A.
    task automatic test_two_words();
        do_reset();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        send_frame(frame);
        tests++; if (wr_addr.size() !== 2) begin fails++; $display("FAIL two_words_count got=%0d exp=2", wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            tests++; if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h12345678) begin fails++;
                $display("FAIL two_words_w0 got=%0d:%08h exp=0:12345678", wr_addr[0], wr_data[0]); end
            tests++; if (wr_addr[1] !== 10'd1 || wr_data[1] !== 32'hDEADBEEF) begin fails++;
                $display("FAIL two_words_w1 got=%0d:%08h exp=1:deadbeef", wr_addr[1], wr_data[1]); end
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL two_words_done got=%b exp=1", done); end
        tests++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL two_words_hold got=%b exp=0", cpu_hold); end
        tests++; if (ram_we !== 1'b0 || ram_addr !== 10'd1 || ram_wdata !== 32'hDEADBEEF) begin fails++;
            $display("FAIL two_words_hold_bus got=%b/%0d/%08h exp=0/1/deadbeef", ram_we, ram_addr, ram_wdata); end
        // DONE is terminal: another sync must not disturb it.
        send_byte(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        tests++; if (done !== 1'b1 || error !== 1'b0) begin fails++;
            $display("FAIL two_words_terminal got done=%b err=%b exp done=1 err=0", done, error); end
        $display("[TB] test_two_words complete");
    endtask

    task automatic test_bad_csum();
        do_reset();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        send_frame(frame);
        tests++; if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin fails++;
            $display("FAIL bad_csum_flags got err=%b done=%b hold=%b exp 1/0/1", error, done, cpu_hold); end
        send_byte(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL bad_csum_sync_clear got=%b exp=0", error); end
        wr_addr.delete();
        wr_data.delete();
        frame = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        send_frame(frame);
        tests++; if (error !== 1'b0 || done !== 1'b1) begin fails++;
            $display("FAIL bad_csum_reload got err=%b done=%b exp 0/1", error, done); end
        tests++; if (wr_addr.size() !== 2) begin fails++; $display("FAIL bad_csum_reload_count got=%0d exp=2", wr_addr.size()); end
        $display("[TB] test_bad_csum complete");
    endtask

    task automatic test_empty_and_oversize();
        do_reset();
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(frame);
        tests++; if (wr_addr.size() !== 0) begin fails++; $display("FAIL empty_count got=%0d exp=0", wr_addr.size()); end
        tests++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin fails++;
            $display("FAIL empty_done got done=%b hold=%b exp 1/0", done, cpu_hold); end
        do_reset();
        frame = '{8'hA5, 8'h01, 8'h04};
        send_frame(frame);
        tests++; if (error !== 1'b1 || done !== 1'b0) begin fails++;
            $display("FAIL oversize_error got err=%b done=%b exp 1/0", error, done); end
        tests++; if (wr_addr.size() !== 0) begin fails++; $display("FAIL oversize_count got=%0d exp=0", wr_addr.size()); end
        $display("[TB] test_empty_and_oversize complete");
    endtask

    task automatic test_junk_glitch();
        do_reset();
        // Single-cycle low pulse with the line otherwise idle.
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        frame = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_frame(frame);
        // Another glitch between data bytes: a decoded byte here would
        // corrupt the word.
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        frame = '{8'h33, 8'h44, 8'h44};
        send_frame(frame);
        tests++; if (wr_addr.size() !== 1) begin fails++; $display("FAIL junk_count got=%0d exp=1", wr_addr.size()); end
        if (wr_addr.size() == 1) begin
            tests++; if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h44332211) begin fails++;
                $display("FAIL junk_w0 got=%0d:%08h exp=0:44332211", wr_addr[0], wr_data[0]); end
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL junk_done got=%b exp=1", done); end
        $display("[TB] test_junk_glitch complete");
    endtask

    task automatic test_framing();
        do_reset();
        frame = '{8'hA5, 8'h01, 8'h00, 8'h11};
        send_frame(frame);
        send_byte(8'h22, 1'b0);
        repeat (4) @(negedge clk);
        tests++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin fails++;
            $display("FAIL framing_flags got err=%b hold=%b done=%b exp 1/1/0", error, cpu_hold, done); end
        frame = '{8'h33, 8'h44};
        send_frame(frame);
        tests++; if (wr_addr.size() !== 0) begin fails++; $display("FAIL framing_count got=%0d exp=0", wr_addr.size()); end
        tests++; if (error !== 1'b1) begin fails++; $display("FAIL framing_sticky got=%b exp=1", error); end
        $display("[TB] test_framing complete");
    endtask

    task automatic test_reset_mid();
        do_reset();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56};
        send_frame(frame);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (ram_we !== 1'b0 || ram_addr !== 10'd0 || ram_wdata !== 32'd0) begin fails++;
            $display("FAIL mid_reset_bus got=%b/%0d/%08h exp=0/0/0", ram_we, ram_addr, ram_wdata); end
        tests++; if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin fails++;
            $display("FAIL mid_reset_flags got hold=%b done=%b err=%b exp 1/0/0", cpu_hold, done, error); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        send_frame(frame);
        tests++; if (wr_addr.size() !== 2) begin fails++; $display("FAIL mid_reload_count got=%0d exp=2", wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            tests++; if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h12345678) begin fails++;
                $display("FAIL mid_reload_w0 got=%0d:%08h exp=0:12345678", wr_addr[0], wr_data[0]); end
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL mid_reload_done got=%b exp=1", done); end
        $display("[TB] test_reset_mid complete");
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_bad_csum();
        test_empty_and_oversize();
        test_junk_glitch();
        test_framing();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
